pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/riscv_pipe_pkg.sv | 26 ++
 rtl/fwd_unit.sv | 23 ++
 rtl/pipe_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard control.
package riscv_pipe_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 64;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned FWD_W           = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } pipe_state_t;

  typedef enum logic [FWD_W-1:0] {
    FWD_REGFILE = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2
  } fwd_sel_t;

  // True when a write to dst is visible to a read of src; x0 never matches.
  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand bypass selection for one ID source register: MEM beats WB beats regfile.
module fwd_unit
  import riscv_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wb_en,
  output fwd_sel_t         sel
);

  // Youngest producer wins so the operand sees the most recent write.
  always_comb begin
    sel = FWD_REGFILE;
    if (mem_wb_en && reg_hit(rs, mem_rd)) begin
      sel = FWD_MEM;
    end else if (wb_wb_en && reg_hit(rs, wb_rd)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: dmem wait stalls with timeout, branch redirect
// flushes, load-use interlock and operand forwarding selects.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wb_en,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             bubble_m_wb,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             mem_fault
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  pipe_state_t      state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_busy;
  logic             busy_eff;
  logic             load_use;
  fwd_sel_t         fwd_a_sel;
  fwd_sel_t         fwd_b_sel;

  // Once the memory has timed out the pipeline no longer waits on it.
  assign mem_busy = dmem_req && !dmem_ready;
  assign busy_eff = mem_busy && !mem_fault;

  assign load_use = ex_is_load &&
                    ((id_use_rs1 && reg_hit(id_rs1, ex_rd)) ||
                     (id_use_rs2 && reg_hit(id_rs2, ex_rd)));

  // Control state, dmem wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      unique case (state)
        ST_MEM_WAIT: begin
          if (busy_eff) begin
            if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
              mem_fault <= 1'b1;
              state     <= ST_RUN;
              wait_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end else begin
            wait_cnt <= '0;
            state    <= ex_branch_taken ? ST_REDIRECT : ST_RUN;
          end
        end
        ST_REDIRECT: begin
          state <= busy_eff ? ST_MEM_WAIT : ST_RUN;
        end
        default: begin
          if (busy_eff) begin
            state <= ST_MEM_WAIT;
          end else if (ex_branch_taken) begin
            state <= ST_REDIRECT;
          end else begin
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

  // Stall/flush decode by priority: reset, mem busy, redirect/branch, load-use.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    bubble_m_wb = 1'b0;
    if (!rst) begin
      bubble_m_wb = 1'b1;
    end else if (busy_eff) begin
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      stall_ex    = 1'b1;
      stall_mem   = 1'b1;
      bubble_m_wb = 1'b1;
    end else if (state == ST_REDIRECT) begin
      flush_if_id = 1'b1;
    end else if (ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  fwd_unit u_fwd_a (
    .rs        (id_rs1),
    .mem_rd    (mem_rd),
    .mem_wb_en (mem_wb_en),
    .wb_rd     (wb_rd),
    .wb_wb_en  (wb_wb_en),
    .sel       (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .rs        (id_rs2),
    .mem_rd    (mem_rd),
    .mem_wb_en (mem_wb_en),
    .wb_rd     (wb_rd),
    .wb_wb_en  (wb_wb_en),
    .sel       (fwd_b_sel)
  );

  assign fwd_a = FWD_W'(fwd_a_sel);
  assign fwd_b = FWD_W'(fwd_b_sel);

`ifdef PIPE_CTRL_PERF_EN
  logic any_stall;
  logic any_flush;

  assign any_stall = stall_if || stall_id || stall_ex || stall_mem;
  assign any_flush = flush_if_id || flush_id_ex;

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (any_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (any_flush && (flush_count != '1)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a scoreboard queue of expected output vectors.
module tb_pipe_ctrl;

  localparam int unsigned TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
  logic       mem_wb_en, wb_wb_en, dmem_req, dmem_ready;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_if_id, flush_id_ex, bubble_m_wb, mem_fault;
  logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  logic [11:0] obs;
  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .mem_wb_en       (mem_wb_en),
    .wb_rd           (wb_rd),
    .wb_wb_en        (wb_wb_en),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .stall_mem       (stall_mem),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .bubble_m_wb     (bubble_m_wb),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mem_fault       (mem_fault)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  assign obs = {stall_if, stall_id, stall_ex, stall_mem, flush_if_id, flush_id_ex,
                bubble_m_wb, fwd_a, fwd_b, mem_fault};

  function automatic logic [11:0] ex(input logic si, input logic sd, input logic se,
                                     input logic sm, input logic fi, input logic fd,
                                     input logic bub, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic mf);
    return {si, sd, se, sm, fi, fd, bub, fa, fb, mf};
  endfunction

  function automatic logic [11:0] e_idle(input logic mf);
    return ex(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, mf);
  endfunction
  function automatic logic [11:0] e_rst(input logic mf);
    return ex(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, mf);
  endfunction
  function automatic logic [11:0] e_busy(input logic mf);
    return ex(1, 1, 1, 1, 0, 0, 1, 2'd0, 2'd0, mf);
  endfunction
  function automatic logic [11:0] e_lu(input logic mf);
    return ex(1, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, mf);
  endfunction
  function automatic logic [11:0] e_br(input logic mf);
    return ex(0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, mf);
  endfunction
  function automatic logic [11:0] e_rd(input logic mf);
    return ex(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, mf);
  endfunction

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = '0; mem_wb_en = 1'b0; wb_rd = '0; wb_wb_en = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  // Queue the expectation for the inputs just driven, check it mid-cycle,
  // then advance to just after the next active edge.
  task automatic step(input string tag, input logic [11:0] e);
    logic [11:0] want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    dmem_req = 1'b1;
    @(posedge clk);
    #1;
    step("reset_gate", e_rst(0));

    rst = 1'b1;
    clear_in();
    step("idle", e_idle(0));

    // Load-use interlock
    set_load_use();
    step("lu_rs1", e_lu(0));
    clear_in();
    step("lu_release", e_idle(0));
    ex_is_load = 1'b1; ex_rd = 5'd6; id_rs2 = 5'd6;
    step("lu_rs2_unused", e_idle(0));
    id_use_rs2 = 1'b1;
    step("lu_rs2", e_lu(0));
    clear_in();
    ex_is_load = 1'b1; id_use_rs1 = 1'b1;
    step("lu_x0", e_idle(0));

    // Branch redirect
    clear_in();
    ex_branch_taken = 1'b1;
    step("br_taken", e_br(0));
    ex_branch_taken = 1'b0;
    step("br_redirect", e_rd(0));
    step("br_done", e_idle(0));

    ex_branch_taken = 1'b1;
    set_load_use();
    step("br_over_lu", e_br(0));
    step("redirect_ignores_br", e_rd(0));
    clear_in();
    step("redirect_done", e_idle(0));

    // Memory wait with coincident branch and load-use suppressed
    dmem_req = 1'b1; ex_branch_taken = 1'b1;
    set_load_use();
    for (int i = 0; i < 3; i++) step("mem_wait", e_busy(0));
    clear_in();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    step("mem_ready", e_idle(0));
    clear_in();
    step("mem_run", e_idle(0));
    ex_branch_taken = 1'b1;
    step("br_after_mem", e_br(0));
    clear_in();
    step("redirect_after_mem", e_rd(0));
    step("idle_after_mem", e_idle(0));

    // Forwarding
    mem_rd = 5'd7; wb_rd = 5'd7; mem_wb_en = 1'b1; wb_wb_en = 1'b1;
    id_rs1 = 5'd7; id_rs2 = 5'd7;
    step("fwd_mem", ex(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 0));
    mem_wb_en = 1'b0;
    step("fwd_wb", ex(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 0));
    id_rs2 = 5'd3;
    step("fwd_b_none", ex(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0));
    mem_wb_en = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    step("fwd_x0", e_idle(0));
    mem_rd = 5'd4; wb_rd = 5'd9; id_rs1 = 5'd4; id_rs2 = 5'd9;
    step("fwd_mixed", ex(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 0));
    mem_wb_en = 1'b0; wb_wb_en = 1'b0;
    step("fwd_disabled", e_idle(0));

    // Timeout: one RUN cycle plus TMO wait cycles, then fault and release
    clear_in();
    dmem_req = 1'b1;
    for (int i = 0; i < 1 + TMO; i++) step("tmo_stall", e_busy(0));
    step("tmo_fault", e_idle(1));
    dmem_req = 1'b0;
    step("fault_sticky", e_idle(1));
    set_load_use();
    step("fault_lu", e_lu(1));

    // Reset clears fault; reset in the middle of a wait abandons it
    clear_in();
    rst = 1'b0; dmem_req = 1'b1;
    step("rst_clear", e_rst(1));
    rst = 1'b1;
    step("rmw_run", e_busy(0));
    step("rmw_wait", e_busy(0));
    rst = 1'b0;
    step("rmw_rst", e_rst(0));
    rst = 1'b1;
    clear_in();
    step("rmw_after", e_idle(0));
    dmem_req = 1'b1;
    for (int i = 0; i < 1 + TMO; i++) step("rmw_recount", e_busy(0));
    step("rmw_fault", e_idle(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
